// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_stage.sv
// One stage of the universal shift register: a WIDTH-bit word plus its valid
// bit, with a 4-way next-value select (hold / up neighbour / down neighbour /
// parallel load) and a synchronous clear that overrides everything.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] up_nbr_i,   // word arriving on shift up (lower stage or sin_up)
  input  logic             up_vld_i,   // its valid bit (tied high at stage 0)
  input  logic [WIDTH-1:0] dn_nbr_i,   // word arriving on shift down (upper stage or sin_dn)
  input  logic             dn_vld_i,   // its valid bit (tied high at the last stage)
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // Next-state select: clr beats an enabled operation, which beats hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      data_d = '0;
      vld_d  = 1'b0;
    end else if (en_i) begin
      unique case (mode_i)
        MODE_UP: begin
          data_d = up_nbr_i;
          vld_d  = up_vld_i;
        end
        MODE_DN: begin
          data_d = dn_nbr_i;
          vld_d  = dn_vld_i;
        end
        MODE_LOAD: begin
          data_d = load_i;
          vld_d  = 1'b1;
        end
        default: begin
          data_d = data_q;
          vld_d  = vld_q;
        end
      endcase
    end
  end

  // Stage register; async reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: DEPTH stages of WIDTH-bit words with
// bidirectional shift, parallel load/readout, clear, enable and per-stage
// valid tracking. Every output comes straight from the stage registers.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_up,
  input  logic [WIDTH-1:0]       sin_dn,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH-1:0]       q_first,
  output logic [WIDTH-1:0]       q_last,
  output logic [DEPTH-1:0]       vld,
  output logic                   full,
  output logic                   empty
);

  logic [WIDTH-1:0] stage_w [DEPTH];
  logic [DEPTH-1:0] vld_w;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] up_nbr, dn_nbr;
    logic             up_vld, dn_vld;

    // Chain ends take the serial inputs and always insert a valid word.
    if (i == 0) begin : g_first
      assign up_nbr = sin_up;
      assign up_vld = 1'b1;
    end else begin : g_up
      assign up_nbr = stage_w[i-1];
      assign up_vld = vld_w[i-1];
    end

    if (i == DEPTH-1) begin : g_last
      assign dn_nbr = sin_dn;
      assign dn_vld = 1'b1;
    end else begin : g_dn
      assign dn_nbr = stage_w[i+1];
      assign dn_vld = vld_w[i+1];
    end

    usr_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .clr_i    (clr),
      .mode_i   (mode),
      .up_nbr_i (up_nbr),
      .up_vld_i (up_vld),
      .dn_nbr_i (dn_nbr),
      .dn_vld_i (dn_vld),
      .load_i   (pin[i*WIDTH +: WIDTH]),
      .q_o      (stage_w[i]),
      .vld_o    (vld_w[i])
    );

    assign pout[i*WIDTH +: WIDTH] = stage_w[i];
  end

  assign q_first = stage_w[0];
  assign q_last  = stage_w[DEPTH-1];
  assign vld     = vld_w;
  assign full    = &vld_w;
  assign empty   = ~|vld_w;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with WIDTH=4, DEPTH=3.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W = 4;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, clr;
  logic [1:0]     mode;
  logic [W-1:0]   sin_up, sin_dn;
  logic [W*D-1:0] pin;
  logic [W*D-1:0] pout;
  logic [W-1:0]   q_first, q_last;
  logic [D-1:0]   vld;
  logic           full, empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .mode    (mode),
    .sin_up  (sin_up),
    .sin_dn  (sin_dn),
    .pin     (pin),
    .pout    (pout),
    .q_first (q_first),
    .q_last  (q_last),
    .vld     (vld),
    .full    (full),
    .empty   (empty)
  );

  typedef struct {
    logic           clr;
    logic           en;
    logic [1:0]     mode;
    logic [W-1:0]   sin_up;
    logic [W-1:0]   sin_dn;
    logic [W*D-1:0] pin;
    logic [W*D-1:0] e_pout;
    logic [D-1:0]   e_vld;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic c, logic e, logic [1:0] m, logic [W-1:0] su,
                              logic [W-1:0] sd, logic [W*D-1:0] p,
                              logic [W*D-1:0] ep, logic [D-1:0] ev);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.sin_up = su; v.sin_dn = sd; v.pin = p;
    v.e_pout = ep; v.e_vld = ev;
    return v;
  endfunction

  // Compare all outputs against expected stage contents and valid bits.
  // q_first/q_last/full/empty are derived from the expected values.
  task automatic check(input string name, input logic [W*D-1:0] ep, input logic [D-1:0] ev);
    logic [24:0] act, exp;
    act = {pout, vld, q_first, q_last, full, empty};
    exp = {ep, ev, ep[W-1:0], ep[W*D-1 -: W], &ev, ~|ev};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pout=%h vld=%b qf=%h ql=%h full=%b empty=%b, want pout=%h vld=%b qf=%h ql=%h full=%b empty=%b",
               name, pout, vld, q_first, q_last, full, empty,
               ep, ev, ep[W-1:0], ep[W*D-1 -: W], &ev, ~|ev);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic [1:0] m,
                      input logic [W-1:0] su, input logic [W-1:0] sd,
                      input logic [W*D-1:0] p);
    clr = c; en = e; mode = m; sin_up = su; sin_dn = sd; pin = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Latency: single 1 walks up the chain, q_last high for one cycle
    vecs[0]  = mk(0, 1, MODE_UP,   4'h1, 4'h0, 12'h000, 12'h001, 3'b001);
    vecs[1]  = mk(0, 1, MODE_UP,   4'h0, 4'h0, 12'h000, 12'h010, 3'b011);
    vecs[2]  = mk(0, 1, MODE_UP,   4'h0, 4'h0, 12'h000, 12'h100, 3'b111);
    vecs[3]  = mk(0, 1, MODE_UP,   4'h0, 4'h0, 12'h000, 12'h000, 3'b111);
    // Parallel load then shift down
    vecs[4]  = mk(0, 1, MODE_LOAD, 4'h0, 4'h0, 12'hCBA, 12'hCBA, 3'b111);
    vecs[5]  = mk(0, 1, MODE_DN,   4'h0, 4'h5, 12'h000, 12'h5CB, 3'b111);
    // Hold with enable low even though mode requests shift
    vecs[6]  = mk(0, 1, MODE_LOAD, 4'h0, 4'h0, 12'h123, 12'h123, 3'b111);
    vecs[7]  = mk(0, 0, MODE_UP,   4'hF, 4'h0, 12'h000, 12'h123, 3'b111);
    vecs[8]  = mk(0, 0, MODE_UP,   4'hF, 4'h0, 12'h000, 12'h123, 3'b111);
    vecs[9]  = mk(0, 0, MODE_UP,   4'hF, 4'h0, 12'h000, 12'h123, 3'b111);
    vecs[10] = mk(0, 0, MODE_UP,   4'hF, 4'h0, 12'h000, 12'h123, 3'b111);
    // Clear beats load
    vecs[11] = mk(1, 1, MODE_LOAD, 4'h0, 4'h0, 12'hFFF, 12'h000, 3'b000);
    // Shift down from empty inserts at top
    vecs[12] = mk(0, 1, MODE_DN,   4'h0, 4'h7, 12'h000, 12'h700, 3'b100);
    vecs[13] = mk(0, 1, MODE_DN,   4'h0, 4'h8, 12'h000, 12'h870, 3'b110);
    vecs[14] = mk(0, 1, MODE_HOLD, 4'hE, 4'hE, 12'hEEE, 12'h870, 3'b110);
    // Clear acts with enable low
    vecs[15] = mk(1, 0, MODE_HOLD, 4'h0, 4'h0, 12'h000, 12'h000, 3'b000);
    // Wrap/overflow: 1,2,3,4 up
    vecs[16] = mk(0, 1, MODE_UP,   4'h1, 4'h0, 12'h000, 12'h001, 3'b001);
    vecs[17] = mk(0, 1, MODE_UP,   4'h2, 4'h0, 12'h000, 12'h012, 3'b011);
    vecs[18] = mk(0, 1, MODE_UP,   4'h3, 4'h0, 12'h000, 12'h123, 3'b111);
    vecs[19] = mk(0, 1, MODE_UP,   4'h4, 4'h0, 12'h000, 12'h234, 3'b111);
    // Shift down while full drops stage 0
    vecs[20] = mk(0, 1, MODE_DN,   4'h0, 4'h9, 12'h000, 12'h923, 3'b111);

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = MODE_HOLD;
    sin_up = '0; sin_dn = '0; pin = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 12'h000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release", 12'h000, 3'b000);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].sin_up, vecs[i].sin_dn, vecs[i].pin);
      check($sformatf("vec%0d", i), vecs[i].e_pout, vecs[i].e_vld);
    end

    // Async reset mid-stream: alternating 1/0 up-shift, then reset between edges
    step(0, 1, MODE_UP, 4'h1, 4'h0, 12'h000);
    step(0, 1, MODE_UP, 4'h0, 4'h0, 12'h000);
    step(0, 1, MODE_UP, 4'h1, 4'h0, 12'h000);
    check("alt_stream", 12'h101, 3'b111);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 12'h000, 3'b000);
    #1;
    rst_n = 1'b1;
    // Refill takes DEPTH edges
    step(0, 1, MODE_UP, 4'hF, 4'h0, 12'h000);
    check("refill1", 12'h00F, 3'b001);
    step(0, 1, MODE_UP, 4'hF, 4'h0, 12'h000);
    check("refill2", 12'h0FF, 3'b011);
    step(0, 1, MODE_UP, 4'hF, 4'h0, 12'h000);
    check("refill3", 12'hFFF, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; generalises the fixed 3-stage, 1-bit serial delay line to DEPTH stages of WIDTH-bit words.
- Adds bidirectional shift, parallel load/readout, synchronous clear, enable, and per-stage valid tracking.
- Used as a configurable delay line, serial/parallel converter or rotate buffer in datapath and test structures.

Parameters:
- WIDTH, 1: bits per stage (>=1).
- DEPTH, 3: number of stages (>=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance/load enable; when 0, state holds (clr still acts).
- clr  in  1  synchronous clear; highest priority after reset.
- mode  in  2  00 hold, 01 shift up, 10 shift down, 11 parallel load.
- sin_up  in  WIDTH  word inserted at stage 0 on shift up.
- sin_dn  in  WIDTH  word inserted at stage DEPTH-1 on shift down.
- pin  in  WIDTH*DEPTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH].
- pout  out  WIDTH*DEPTH  all stages, same packing as pin.
- q_first  out  WIDTH  stage 0.
- q_last  out  WIDTH  stage DEPTH-1 (serial output of up-shift).
- vld  out  DEPTH  per-stage valid bits.
- full  out  1  &vld.
- empty  out  1  ~|vld.

Behaviour:
- Reset (rst_n=0, async): all stages = 0, vld = 0. So pout=q_first=q_last=0, full=0, empty=1. Reset mid-operation discards all contents immediately. First update is on the first rising edge after rst_n rises.
- All outputs are direct register outputs; no combinational path from inputs to outputs.
- Priority per rising edge: clr > (en & mode) > hold.
- clr=1: all stages = 0, vld = 0, regardless of en/mode.
- en=0 or mode=00: stages and vld unchanged.
- Shift up (01):
  - stage0 <= sin_up; stage i <= old stage i-1 for i=1..DEPTH-1.
  - vld[0] <= 1; vld[i] <= old vld[i-1].
  - Old stage DEPTH-1 is discarded.
- Shift down (10):
  - stage DEPTH-1 <= sin_dn; stage i <= old stage i+1 for i=0..DEPTH-2.
  - vld[DEPTH-1] <= 1; vld[i] <= old vld[i+1].
  - Old stage 0 is discarded.
- Parallel load (11): stage i <= pin slice i for all i; vld <= all ones.
- All stages update simultaneously from pre-edge values; every stage advances exactly one position per enabled edge.
- Latency on continuous up-shift: a word at sin_up before edge k appears on q_last after edge k+DEPTH-1, i.e. DEPTH edges to traverse the chain.
- Boundary cases:
  - full: shifting continues; the outgoing word is dropped with no stall or error flag.
  - empty: shift still inserts, so empty deasserts after one shift.
  - Simultaneous clr and load: clr wins.
  - Mode change between edges takes effect on the next edge only.

Decomposition:
- Shared package usr_pkg: mode constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LOAD=2'b11.
- One natural sub-module, usr_stage: a WIDTH-bit register with a 4-way next-value mux (hold/up-neighbour/down-neighbour/load) plus its valid bit. Top level generates DEPTH instances and wires the neighbour ports.
- Edge stages take sin_up/sin_dn as their neighbour inputs.

Test Plan:
- Reset/latency (WIDTH=1, DEPTH=3, en=1, mode=01): deassert rst_n; hold sin_up=1 for one edge, then 0.
  - q_last rises after the 3rd edge, for exactly one cycle.
  - vld goes 001, 011, 111; full=1 at the 3rd edge.
- Parallel load then shift down (WIDTH=4, DEPTH=3): pin=12'hCBA with mode=11, then mode=10 with sin_dn=4'h5.
  - After load: pout=CBA.
  - After the next edge: pout=5CB, q_first=B.
- Hold/enable: load 12'h123, then en=0 with mode=01 for 4 edges.
  - pout stays 123; vld stays 111.
- Clear priority: full register, then clr=1 with mode=11 and pin=FFF.
  - pout=000, vld=000, empty=1.
- Async reset mid-stream: continuous up-shift of alternating 1/0, then pull rst_n low between edges.
  - Outputs go 0 immediately, without waiting for an edge.
  - After release, refill takes DEPTH edges.
- Wrap/overflow: DEPTH=3 up-shift of 1,2,3,4.
  - After the 4th edge: pout=234 (stage2=2, stage0=4); word 1 is discarded; full stays 1.
